costas_regs: RTL and testbench

- CtrlPort responder (slave) on the user side of the costas NoC shell.
- Terminates register requests issued by the shell's CtrlPort master.
- Holds the Costas loop configuration (enable, bypass, loop gains) with atomic, packet-boundary-aligned gain commits.
- Reports lock status and a saturating sample counter.
- Everything runs on the single shell clock, which is shared by CtrlPort and the AXIS data path.

---
 rtl/costas_regs_pkg.sv | 23 ++
 rtl/costas_sat_cnt.sv | 27 ++
 rtl/costas_regs.sv | 150 +++++++++++++++
 tb/tb_costas_regs.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/costas_regs_pkg.sv
// Shared constants for the Costas loop register block: register offsets,
// CTRL/STATUS field positions and the gain width.
package costas_regs_pkg;

  localparam logic [7:0] REG_COMPAT     = 8'h00;
  localparam logic [7:0] REG_CTRL       = 8'h04;
  localparam logic [7:0] REG_ALPHA      = 8'h08;
  localparam logic [7:0] REG_BETA       = 8'h0C;
  localparam logic [7:0] REG_COMMIT     = 8'h10;
  localparam logic [7:0] REG_STATUS     = 8'h14;
  localparam logic [7:0] REG_SAMPLE_CNT = 8'h18;
  localparam logic [7:0] REG_SCRATCH    = 8'h1C;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_RST_BIT = 1;
  localparam int CTRL_BYP_BIT = 2;

  localparam int STAT_LOCK_BIT = 0;
  localparam int STAT_PEND_BIT = 1;

  localparam int GAIN_W = 16;

endpackage

// File: rtl/costas_sat_cnt.sv
// 32-bit saturating event counter with clear-on-read; an increment that
// coincides with the clear is kept, so the count restarts at 1.
module costas_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;
  logic        w_at_max;

  assign w_at_max = (r_cnt == 32'hFFFF_FFFF);
  assign o_cnt    = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? 32'd1 : 32'd0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/costas_regs.sv
// CtrlPort responder holding the Costas loop configuration, shadowed gains
// committed on packet boundaries, lock status and a sample counter.
module costas_regs
  import costas_regs_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR  = 20'h00000,
  parameter int          AW         = 8,
  parameter logic [31:0] COMPAT_NUM = 32'h0001_0000,
  parameter logic [15:0] ALPHA_RST  = 16'h0100,
  parameter logic [15:0] BETA_RST   = 16'h0010
) (
  input  logic        ctrlport_clk,
  input  logic        ctrlport_rst,
  input  logic        s_ctrlport_req_wr,
  input  logic        s_ctrlport_req_rd,
  input  logic [19:0] s_ctrlport_req_addr,
  input  logic [31:0] s_ctrlport_req_data,
  output logic        s_ctrlport_resp_ack,
  output logic [31:0] s_ctrlport_resp_data,
  input  logic        sample_stb,
  input  logic        pkt_eop,
  input  logic        lock,
  output logic        loop_enable,
  output logic        loop_bypass,
  output logic        loop_rst,
  output logic [15:0] alpha,
  output logic [15:0] beta
);

  // Handshake: a single-cycle wr or rd strobe is a request (wr wins when both
  // are set); every in-range request gets exactly one ack on the next cycle,
  // with read data valid only alongside ack and zero otherwise.
  logic              w_in_range;
  logic              w_wr;
  logic              w_rd;
  logic [AW-1:0]     w_offs;
  logic              w_sel_ctrl;
  logic              w_sel_alpha;
  logic              w_sel_beta;
  logic              w_sel_commit;
  logic              w_sel_cnt;
  logic              w_sel_scratch;
  logic              w_apply;
  logic [31:0]       w_rdata;
  logic [31:0]       w_cnt;
  logic              w_unused;

  logic              r_ack;
  logic [31:0]       r_resp_data;
  logic              r_enable;
  logic              r_bypass;
  logic              r_loop_rst;
  logic              r_commit_pending;
  logic [GAIN_W-1:0] r_alpha;
  logic [GAIN_W-1:0] r_beta;
  logic [GAIN_W-1:0] r_sh_alpha;
  logic [GAIN_W-1:0] r_sh_beta;
  logic [31:0]       r_scratch;

  assign w_unused   = ^s_ctrlport_req_addr[1:0];
  assign w_in_range = (s_ctrlport_req_addr[19:AW] == BASE_ADDR[19:AW]);
  assign w_wr       = s_ctrlport_req_wr & w_in_range;
  assign w_rd       = s_ctrlport_req_rd & ~s_ctrlport_req_wr & w_in_range;
  assign w_offs     = {s_ctrlport_req_addr[AW-1:2], 2'b00};

  assign w_sel_ctrl    = (w_offs == AW'(REG_CTRL));
  assign w_sel_alpha   = (w_offs == AW'(REG_ALPHA));
  assign w_sel_beta    = (w_offs == AW'(REG_BETA));
  assign w_sel_commit  = (w_offs == AW'(REG_COMMIT));
  assign w_sel_cnt     = (w_offs == AW'(REG_SAMPLE_CNT));
  assign w_sel_scratch = (w_offs == AW'(REG_SCRATCH));

  // Gains may only change at a packet boundary, or any time the loop is idle.
  assign w_apply = r_commit_pending & (pkt_eop | ~r_enable);

  always_comb begin
    w_rdata = '0;
    case (w_offs)
      AW'(REG_COMPAT):     w_rdata = COMPAT_NUM;
      AW'(REG_CTRL): begin
        w_rdata[CTRL_EN_BIT]  = r_enable;
        w_rdata[CTRL_BYP_BIT] = r_bypass;
      end
      AW'(REG_ALPHA):      w_rdata[GAIN_W-1:0] = r_sh_alpha;
      AW'(REG_BETA):       w_rdata[GAIN_W-1:0] = r_sh_beta;
      AW'(REG_STATUS): begin
        w_rdata[STAT_LOCK_BIT] = lock;
        w_rdata[STAT_PEND_BIT] = r_commit_pending;
      end
      AW'(REG_SAMPLE_CNT): w_rdata = w_cnt;
      AW'(REG_SCRATCH):    w_rdata = r_scratch;
      default:             w_rdata = '0;
    endcase
  end

  always_ff @(posedge ctrlport_clk) begin
    if (ctrlport_rst) begin
      r_ack            <= 1'b0;
      r_resp_data      <= '0;
      r_enable         <= 1'b0;
      r_bypass         <= 1'b0;
      r_loop_rst       <= 1'b0;
      r_commit_pending <= 1'b0;
      r_alpha          <= ALPHA_RST;
      r_beta           <= BETA_RST;
      r_sh_alpha       <= ALPHA_RST;
      r_sh_beta        <= BETA_RST;
      r_scratch        <= '0;
    end else begin
      r_ack       <= w_wr | w_rd;
      r_resp_data <= w_rd ? w_rdata : 32'd0;
      r_loop_rst  <= w_wr & w_sel_ctrl & s_ctrlport_req_data[CTRL_RST_BIT];
      if (w_wr && w_sel_ctrl) begin
        r_enable <= s_ctrlport_req_data[CTRL_EN_BIT];
        r_bypass <= s_ctrlport_req_data[CTRL_BYP_BIT];
      end
      if (w_apply) begin
        r_alpha <= r_sh_alpha;
        r_beta  <= r_sh_beta;
      end
      // A commit arriving on the apply edge re-arms for the next boundary.
      if (w_wr && w_sel_commit) begin
        r_commit_pending <= 1'b1;
      end else if (w_apply) begin
        r_commit_pending <= 1'b0;
      end
      if (w_wr && w_sel_alpha)   r_sh_alpha <= s_ctrlport_req_data[GAIN_W-1:0];
      if (w_wr && w_sel_beta)    r_sh_beta  <= s_ctrlport_req_data[GAIN_W-1:0];
      if (w_wr && w_sel_scratch) r_scratch  <= s_ctrlport_req_data;
    end
  end

  costas_sat_cnt u_sample_cnt (
    .clk   (ctrlport_clk),
    .rst   (ctrlport_rst),
    .i_inc (sample_stb),
    .i_clr (w_rd & w_sel_cnt),
    .o_cnt (w_cnt)
  );

  // Reset masks a response already in flight so it never reaches the master.
  assign s_ctrlport_resp_ack  = r_ack & ~ctrlport_rst;
  assign s_ctrlport_resp_data = ctrlport_rst ? 32'd0 : r_resp_data;
  assign loop_rst             = r_loop_rst & ~ctrlport_rst;
  assign loop_enable          = r_enable;
  assign loop_bypass          = r_bypass;
  assign alpha                = r_alpha;
  assign beta                 = r_beta;

endmodule

// File: tb/tb_costas_regs.sv
// Bench for costas_regs: directed steps from the test plan followed by a
// randomized phase, all checked against a register-level reference model.
module tb_costas_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_wr;
  logic        req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        sample_stb;
  logic        pkt_eop;
  logic        lock;
  logic        loop_enable;
  logic        loop_bypass;
  logic        loop_rst;
  logic [15:0] alpha;
  logic [15:0] beta;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_en;
  bit          m_byp;
  bit          m_pend;
  logic [15:0] m_alpha;
  logic [15:0] m_beta;
  logic [15:0] m_sh_a;
  logic [15:0] m_sh_b;
  logic [31:0] m_scratch;
  longint      m_cnt;
  logic        e_ack;
  logic [31:0] e_data;
  logic        e_lrst;

  always #5 clk = ~clk;

  costas_regs dut (
    .ctrlport_clk         (clk),
    .ctrlport_rst         (rst),
    .s_ctrlport_req_wr    (req_wr),
    .s_ctrlport_req_rd    (req_rd),
    .s_ctrlport_req_addr  (req_addr),
    .s_ctrlport_req_data  (req_data),
    .s_ctrlport_resp_ack  (resp_ack),
    .s_ctrlport_resp_data (resp_data),
    .sample_stb           (sample_stb),
    .pkt_eop              (pkt_eop),
    .lock                 (lock),
    .loop_enable          (loop_enable),
    .loop_bypass          (loop_bypass),
    .loop_rst             (loop_rst),
    .alpha                (alpha),
    .beta                 (beta)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_en = 0; m_byp = 0; m_pend = 0;
    m_alpha = 16'h0100; m_beta = 16'h0010;
    m_sh_a = 16'h0100; m_sh_b = 16'h0010;
    m_scratch = '0; m_cnt = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit w, r, apply;
    logic [7:0] off;
    w   = (req_addr[19:8] == 12'h000) && req_wr;
    r   = (req_addr[19:8] == 12'h000) && req_rd && !req_wr;
    off = {req_addr[7:2], 2'b00};
    e_ack = w || r; e_data = '0; e_lrst = 0;
    if (r) begin
      case (off)
        8'h00: e_data = 32'h0001_0000;
        8'h04: e_data = {29'd0, m_byp, 1'b0, m_en};
        8'h08: e_data = {16'd0, m_sh_a};
        8'h0C: e_data = {16'd0, m_sh_b};
        8'h14: e_data = {30'd0, m_pend, lock};
        8'h18: e_data = m_cnt[31:0];
        8'h1C: e_data = m_scratch;
        default: e_data = '0;
      endcase
    end
    apply = m_pend && (pkt_eop || !m_en);
    if (apply) begin
      m_alpha = m_sh_a; m_beta = m_sh_b; m_pend = 0;
    end
    if (r && off == 8'h18) m_cnt = sample_stb ? 1 : 0;
    else if (sample_stb && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (w) begin
      case (off)
        8'h04: begin m_en = req_data[0]; m_byp = req_data[2]; e_lrst = req_data[1]; end
        8'h08: m_sh_a = req_data[15:0];
        8'h0C: m_sh_b = req_data[15:0];
        8'h10: m_pend = 1;
        8'h1C: m_scratch = req_data;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ack"},    32'(resp_ack),    32'(e_ack));
    check({tag, ".data"},   resp_data,        e_data);
    check({tag, ".lrst"},   32'(loop_rst),    32'(e_lrst));
    check({tag, ".en"},     32'(loop_enable), 32'(m_en));
    check({tag, ".byp"},    32'(loop_bypass), 32'(m_byp));
    check({tag, ".alpha"},  32'(alpha),       32'(m_alpha));
    check({tag, ".beta"},   32'(beta),        32'(m_beta));
  endtask

  // Drives one cycle of inputs (called at posedge+1), then checks after the edge.
  task automatic op(input string tag, input bit wr, input bit rd, input logic [19:0] addr,
                    input logic [31:0] data, input bit stb, input bit eop, input bit lk);
    req_wr = wr; req_rd = rd; req_addr = addr; req_data = data;
    sample_stb = stb; pkt_eop = eop; lock = lk;
    model_step();
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    op(tag, 0, 0, 20'h0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; req_wr = 0; req_rd = 0; req_addr = '0; req_data = '0;
    sample_stb = 0; pkt_eop = 0; lock = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    e_ack = 0; e_data = 0; e_lrst = 0;
    check_outputs("reset");

    op("rd_compat", 0, 1, 20'h00000, 0, 0, 0, 0);
    op("rd_alpha",  0, 1, 20'h00008, 0, 0, 0, 0);
    op("rd_beta",   0, 1, 20'h0000C, 0, 0, 0, 0);
    idle("idle0");

    op("wr_ctrl",   1, 0, 20'h00004, 32'h3, 0, 0, 0);
    idle("after_ctrl");
    op("rd_ctrl",   0, 1, 20'h00004, 0, 0, 0, 0);

    op("wr_alpha",  1, 0, 20'h00008, 32'h0200, 0, 0, 0);
    op("wr_commit", 1, 0, 20'h00010, 32'h1, 0, 0, 0);
    op("rd_stat_p", 0, 1, 20'h00014, 0, 0, 0, 0);
    idle("hold_gain");
    op("eop",       0, 0, 20'h0, 0, 0, 1, 0);
    op("rd_stat_c", 0, 1, 20'h00014, 0, 0, 0, 1);

    op("commit_eop", 1, 0, 20'h00010, 0, 0, 1, 0);
    op("wr_beta",    1, 0, 20'h0000C, 32'hABCD, 0, 0, 0);
    op("eop_apply",  0, 0, 20'h0, 0, 0, 1, 0);
    op("both_wrrd",  1, 1, 20'h0001C, 32'h1234_5678, 0, 0, 0);
    op("rd_scratch", 0, 1, 20'h0001C, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) op("stb", 0, 0, 20'h0, 0, 1, 0, 0);
    op("rd_cnt5", 0, 1, 20'h00018, 0, 1, 0, 0);
    op("rd_cnt1", 0, 1, 20'h00018, 0, 0, 0, 0);
    op("rd_cnt0", 0, 1, 20'h00018, 0, 0, 0, 0);

    op("rd_unmap", 0, 1, 20'h00040, 0, 0, 0, 0);
    op("rd_oor",   0, 1, 20'h00100, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle("oor_wait");
    op("wr_oor",   1, 0, 20'h0011C, 32'hDEAD_BEEF, 0, 0, 0);
    op("rd_scr2",  0, 1, 20'h0001C, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      int kind, slot;
      logic [19:0] a;
      kind = $urandom_range(0, 3);
      slot = $urandom_range(0, 9);
      if (slot == 9)      a = 20'h00100 | 20'($urandom_range(0, 255));
      else if (slot == 8) a = 20'h00040 | 20'($urandom_range(0, 3));
      else                a = 20'(slot * 4) | 20'($urandom_range(0, 3));
      op("rand", kind[0], kind[1], a, $urandom, $urandom_range(0, 1) == 1,
         $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    // Request immediately followed by reset must never be acknowledged.
    op("pre_rst_ctrl", 1, 0, 20'h00004, 32'h5, 0, 0, 0);
    req_wr = 0; req_rd = 1; req_addr = 20'h00000; req_data = 0;
    @(posedge clk); #1;
    rst = 1; req_rd = 0;
    #1;
    check("rst_ack",  32'(resp_ack), 32'd0);
    check("rst_data", resp_data,     32'd0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    e_ack = 0; e_data = 0; e_lrst = 0;
    check_outputs("post_rst");
    op("rd_alpha_r", 0, 1, 20'h00008, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
